// File: rtl/calc_pkg.sv
// Shared definitions for the calculator's divider arbitration logic.
//   - state_t   : arbiter FSM state encoding
//   - DEF_WIDTH : default operand/result width of the shared divider
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int DEF_WIDTH = 10;

endpackage

// File: rtl/div_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
// Ports:
//   req    in  N_REQ  request levels
//   ptr    in  PTR_W  highest-priority requester index
//   winner out N_REQ  one-hot first set req bit searching upward from ptr (wrapping)
//   any    out 1      at least one req bit is set
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int PTR_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] winner,
    output logic             any
);

    always_comb begin
        winner = '0;
        any    = |req;
        // Walk offsets from farthest to nearest so the nearest hit is the one kept.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N_REQ]) begin
                winner = '0;
                winner[(int'(ptr) + k) % N_REQ] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// div_arbiter: shares one integer divider between N_REQ requesters.
// Round-robin arbitration in IDLE, operands latched for the divider, one start
// pulse, wait for done, then a one-cycle rsp_valid to the granted requester.
// All outputs are registered.
//
// Optional feature macro: DIV_ARB_ZERO_BYPASS_EN
//   defined   : a zero denominator skips the divider and answers
//               quotient=all ones, remainder=numerator, rsp_div_zero=1.
//   undefined : zero denominators go to the divider; rsp_div_zero stays 0.
//
// Ports:
//   clk, reset (async, active low)
//   req / req_numerator / req_denominator   requester side (flattened, i*WIDTH +: WIDTH)
//   grant / rsp_valid / rsp_quotient / rsp_remainder / rsp_div_zero / busy
//   div_start / div_numerator / div_denominator   to the divider
//   div_quotient / div_remainder / div_done       from the divider
//
// state | meaning
// IDLE  | no owner; pick a requester and latch its operands
// ISSUE | start pulse to the divider; advance round-robin pointer
// WAIT  | wait for div_done (first cycle ignores done)
// RESP  | one-cycle rsp_valid to the owner
module div_arbiter
    import calc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N_REQ = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_numerator,
    input  logic [N_REQ*WIDTH-1:0] req_denominator,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]       rsp_quotient,
    output logic [WIDTH-1:0]       rsp_remainder,
    output logic                   rsp_div_zero,
    output logic                   busy,
    output logic                   div_start,
    output logic [WIDTH-1:0]       div_numerator,
    output logic [WIDTH-1:0]       div_denominator,
    input  logic [WIDTH-1:0]       div_quotient,
    input  logic [WIDTH-1:0]       div_remainder,
    input  logic                   div_done
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

`ifdef DIV_ARB_ZERO_BYPASS_EN
    localparam bit ZERO_BYPASS = 1'b1;
`else
    localparam bit ZERO_BYPASS = 1'b0;
`endif

    state_t             state, next_state;
    logic [PTR_W-1:0]   ptr, ptr_nxt;
    logic [PTR_W-1:0]   win_idx, win_idx_nxt;
    logic               wait_first, wait_first_nxt;

    logic [N_REQ-1:0]   pick_onehot;
    logic               pick_any;
    logic [PTR_W-1:0]   pick_idx;
    logic [WIDTH-1:0]   sel_num, sel_den;
    logic               bypass_now;

    logic [N_REQ-1:0]   grant_nxt, rsp_valid_nxt;
    logic [WIDTH-1:0]   rsp_q_nxt, rsp_r_nxt, num_nxt, den_nxt;
    logic               rsp_dz_nxt, busy_nxt, div_start_nxt;

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (pick_onehot),
        .any    (pick_any)
    );

    always_comb begin
        pick_idx = '0;
        sel_num  = '0;
        sel_den  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_onehot[i]) begin
                pick_idx = PTR_W'(i);
                sel_num  = req_numerator[i*WIDTH +: WIDTH];
                sel_den  = req_denominator[i*WIDTH +: WIDTH];
            end
        end
    end

    // Bypass decision uses the latched denominator, so later operand changes cannot affect it.
    assign bypass_now = ZERO_BYPASS && (div_denominator == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            ptr             <= '0;
            win_idx         <= '0;
            wait_first      <= 1'b0;
            grant           <= '0;
            rsp_valid       <= '0;
            rsp_quotient    <= '0;
            rsp_remainder   <= '0;
            rsp_div_zero    <= 1'b0;
            busy            <= 1'b0;
            div_start       <= 1'b0;
            div_numerator   <= '0;
            div_denominator <= '0;
        end else begin
            state           <= next_state;
            ptr             <= ptr_nxt;
            win_idx         <= win_idx_nxt;
            wait_first      <= wait_first_nxt;
            grant           <= grant_nxt;
            rsp_valid       <= rsp_valid_nxt;
            rsp_quotient    <= rsp_q_nxt;
            rsp_remainder   <= rsp_r_nxt;
            rsp_div_zero    <= rsp_dz_nxt;
            busy            <= busy_nxt;
            div_start       <= div_start_nxt;
            div_numerator   <= num_nxt;
            div_denominator <= den_nxt;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pick_any) next_state = ISSUE;
            ISSUE:   next_state = bypass_now ? RESP : WAIT;
            WAIT:    if (!wait_first && div_done) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ptr_nxt        = ptr;
        win_idx_nxt    = win_idx;
        wait_first_nxt = 1'b0;
        grant_nxt      = grant;
        rsp_valid_nxt  = '0;
        rsp_q_nxt      = rsp_quotient;
        rsp_r_nxt      = rsp_remainder;
        rsp_dz_nxt     = 1'b0;
        busy_nxt       = (next_state != IDLE);
        div_start_nxt  = 1'b0;
        num_nxt        = div_numerator;
        den_nxt        = div_denominator;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    grant_nxt     = pick_onehot;
                    win_idx_nxt   = pick_idx;
                    num_nxt       = sel_num;
                    den_nxt       = sel_den;
                    // Start is registered on entry to ISSUE, so the bypass test looks at the selected operand.
                    div_start_nxt = !(ZERO_BYPASS && (sel_den == '0));
                end
            end
            ISSUE: begin
                ptr_nxt = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
                if (bypass_now) begin
                    rsp_valid_nxt = grant;
                    rsp_q_nxt     = '1;
                    rsp_r_nxt     = div_numerator;
                    rsp_dz_nxt    = 1'b1;
                end else begin
                    wait_first_nxt = 1'b1;
                end
            end
            WAIT: begin
                // A done level left over from the previous operation is masked by wait_first.
                if (!wait_first && div_done) begin
                    rsp_valid_nxt = grant;
                    rsp_q_nxt     = div_quotient;
                    rsp_r_nxt     = div_remainder;
                end
            end
            RESP: begin
                grant_nxt = '0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_div_arbiter.sv
module tb_div_arbiter;

    localparam int W = 10;
    localparam int N = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_numerator, req_denominator;
    logic [N-1:0]   grant, rsp_valid;
    logic [W-1:0]   rsp_quotient, rsp_remainder;
    logic           rsp_div_zero, busy, div_start;
    logic [W-1:0]   div_numerator, div_denominator;
    logic [W-1:0]   div_quotient, div_remainder;
    logic           div_done;

    div_arbiter #(.WIDTH(W), .N_REQ(N)) dut (
        .clk             (clk),
        .reset           (reset),
        .req             (req),
        .req_numerator   (req_numerator),
        .req_denominator (req_denominator),
        .grant           (grant),
        .rsp_valid       (rsp_valid),
        .rsp_quotient    (rsp_quotient),
        .rsp_remainder   (rsp_remainder),
        .rsp_div_zero    (rsp_div_zero),
        .busy            (busy),
        .div_start       (div_start),
        .div_numerator   (div_numerator),
        .div_denominator (div_denominator),
        .div_quotient    (div_quotient),
        .div_remainder   (div_remainder),
        .div_done        (div_done)
    );

    always #5 clk = ~clk;

    // Divider stand-in: result after div_lat cycles; with hold_done the done
    // level stays high until the cycle after the next start.
    int           div_lat   = 3;
    bit           hold_done = 1'b0;
    int           div_cnt;
    logic [W-1:0] pend_q, pend_r;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt       <= 0;
            div_done      <= 1'b0;
            div_quotient  <= '0;
            div_remainder <= '0;
            pend_q        <= '0;
            pend_r        <= '0;
        end else if (div_start) begin
            div_cnt <= div_lat;
            pend_q  <= (div_denominator == 0) ? '1 : div_numerator / div_denominator;
            pend_r  <= (div_denominator == 0) ? div_numerator : div_numerator % div_denominator;
        end else if (div_cnt > 1) begin
            div_cnt  <= div_cnt - 1;
            div_done <= 1'b0;
        end else if (div_cnt == 1) begin
            div_cnt       <= 0;
            div_done      <= 1'b1;
            div_quotient  <= pend_q;
            div_remainder <= pend_r;
        end else if (!hold_done) begin
            div_done <= 1'b0;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req   = '0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int who, input logic [W-1:0] num, input logic [W-1:0] den);
        req_numerator[who*W +: W]   = num;
        req_denominator[who*W +: W] = den;
    endtask

    // One isolated transaction from requester 'who'.
    task automatic run_one(input int who, input logic [W-1:0] num, input logic [W-1:0] den,
                           input logic [W-1:0] eq, input logic [W-1:0] er,
                           input int estarts, input bit edz, input string tag);
        int nstart = 0;
        bit got    = 1'b0;
        set_ops(who, num, den);
        req[who] = 1'b1;
        for (int c = 0; c < 200 && !got; c++) begin
            @(posedge clk);
            #1;
            if (div_start) nstart++;
            if (rsp_valid != 0) got = 1'b1;
        end
        if (!got) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1 << who);
            chk({tag, "_grant"}, 32'(grant), 32'd1 << who);
            chk({tag, "_quotient"}, 32'(rsp_quotient), 32'(eq));
            chk({tag, "_remainder"}, 32'(rsp_remainder), 32'(er));
            chk({tag, "_div_zero"}, 32'(rsp_div_zero), 32'(edz));
        end
        req[who] = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
        chk({tag, "_grant_after"}, 32'(grant | rsp_valid), 32'd0);
        chk({tag, "_starts"}, 32'(nstart), 32'(estarts));
    endtask

    typedef struct {
        int           who;
        logic [W-1:0] num;
        logic [W-1:0] den;
        logic [W-1:0] q;
        logic [W-1:0] r;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int           order[6];
        int           nresp, overlaps, idx, exp_w, active, model_ptr;
        bit           got;
        logic [N-1:0] req_before, grant_prev;
        logic [W-1:0] rn[N], rd[N];
        int           gap[N];
        logic [W-1:0] cq[2], cr[2];

        vecs[0] = '{0,   57,   13,    4, 5};
        vecs[1] = '{1,  100,    7,   14, 2};
        vecs[2] = '{0,   45,    6,    7, 3};
        vecs[3] = '{1,    0,    5,    0, 0};
        vecs[4] = '{0, 1023,    1, 1023, 0};
        vecs[5] = '{1,    5,    9,    0, 5};
        vecs[6] = '{0, 1000, 1000,    1, 0};
        vecs[7] = '{1, 1023, 1023,    1, 0};

        req             = '0;
        req_numerator   = '0;
        req_denominator = '0;
        reset           = 1'b1;
        #1 reset = 1'b0;
        #2;
        chk("rst_grant", 32'(grant), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_div_start", 32'(div_start), 0);
        chk("rst_div_zero", 32'(rsp_div_zero), 0);
        chk("rst_rsp_q", 32'(rsp_quotient), 0);
        chk("rst_rsp_r", 32'(rsp_remainder), 0);
        chk("rst_div_num", 32'(div_numerator), 0);
        chk("rst_div_den", 32'(div_denominator), 0);
        do_reset();

        // Single requests from the vector table at a few divider latencies.
        for (int k = 0; k < 8; k++) begin
            div_lat = 1 + (k % 4);
            run_one(vecs[k].who, vecs[k].num, vecs[k].den, vecs[k].q, vecs[k].r, 1, 1'b0,
                    $sformatf("vec%0d", k));
        end
        div_lat = 3;

        // Contention: pointer is 0 after reset, so requester 0 goes first.
        do_reset();
        set_ops(0, 100, 7);
        set_ops(1, 45, 6);
        cq[0] = 14; cr[0] = 2;
        cq[1] = 7;  cr[1] = 3;
        req      = 2'b11;
        nresp    = 0;
        overlaps = 0;
        for (int c = 0; c < 300 && nresp < 2; c++) begin
            @(posedge clk);
            #1;
            if (grant == 2'b11) overlaps++;
            if (rsp_valid != 0) begin
                idx = rsp_valid[1] ? 1 : 0;
                chk($sformatf("cont_order%0d", nresp), 32'(idx), 32'(nresp));
                chk($sformatf("cont_q%0d", nresp), 32'(rsp_quotient), 32'(cq[nresp]));
                chk($sformatf("cont_r%0d", nresp), 32'(rsp_remainder), 32'(cr[nresp]));
                req[idx] = 1'b0;
                nresp++;
            end
        end
        chk("cont_count", 32'(nresp), 2);
        chk("cont_overlap", 32'(overlaps), 0);

        // Fairness: both held high, six back-to-back transactions.
        do_reset();
        set_ops(0, 57, 13);
        set_ops(1, 45, 6);
        req   = 2'b11;
        nresp = 0;
        for (int c = 0; c < 500 && nresp < 6; c++) begin
            @(posedge clk);
            #1;
            if (rsp_valid != 0) begin
                order[nresp] = rsp_valid[1] ? 1 : 0;
                nresp++;
                if (nresp == 6) req = '0;
            end
        end
        chk("fair_count", 32'(nresp), 6);
        for (int k = 0; k < 6; k++) chk($sformatf("fair_order%0d", k), 32'(order[k]), 32'(k % 2));
        repeat (3) @(posedge clk);
        #1;

        // Stale done level must not be taken as the next result.
        do_reset();
        hold_done = 1'b1;
        div_lat   = 3;
        run_one(0, 57, 13, 4, 5, 1, 1'b0, "stale_a");
        run_one(1, 1023, 10, 102, 3, 1, 1'b0, "stale_b");
        hold_done = 1'b0;

        // Reset while waiting on the divider.
        do_reset();
        div_lat = 8;
        set_ops(0, 500, 3);
        req[0] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_busy_before", 32'(busy), 1);
        #2 reset = 1'b0;
        #1;
        chk("midrst_outputs", 32'({grant, rsp_valid, busy, div_start, rsp_div_zero}), 0);
        chk("midrst_buses", 32'(rsp_quotient | rsp_remainder | div_numerator | div_denominator), 0);
        req = '0;
        got = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (rsp_valid != 0) got = 1'b1;
        end
        reset = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (rsp_valid != 0) got = 1'b1;
        end
        chk("midrst_no_rsp", 32'(got), 0);
        div_lat = 3;
        run_one(0, 9, 2, 4, 1, 1, 1'b0, "after_rst");

`ifdef DIV_ARB_ZERO_BYPASS_EN
        run_one(0, 77, 0, 1023, 77, 0, 1'b1, "zero_bypass");
        run_one(1, 77, 7, 11, 0, 1, 1'b0, "after_bypass");
`endif

        // Randomised traffic against a round-robin reference.
        do_reset();
        model_ptr  = 0;
        active     = 0;
        grant_prev = '0;
        nresp      = 0;
        for (int i = 0; i < N; i++) gap[i] = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            req_before = req;
            @(posedge clk);
            #1;
            if (grant != 0 && grant_prev == 0) begin
                exp_w = -1;
                for (int k = 0; k < N; k++) begin
                    if (exp_w < 0 && req_before[(model_ptr + k) % N]) exp_w = (model_ptr + k) % N;
                end
                if (exp_w < 0) begin
                    chk("rand_grant_without_req", 32'(grant), 0);
                end else begin
                    chk("rand_grant", 32'(grant), 32'd1 << exp_w);
                    active    = exp_w;
                    model_ptr = (exp_w + 1) % N;
                end
            end
            if (rsp_valid != 0) begin
                chk("rand_rsp_valid", 32'(rsp_valid), 32'd1 << active);
                chk("rand_q", 32'(rsp_quotient), 32'(rn[active] / rd[active]));
                chk("rand_r", 32'(rsp_remainder), 32'(rn[active] % rd[active]));
                chk("rand_div_zero", 32'(rsp_div_zero), 0);
                req[active] = 1'b0;
                gap[active] = $urandom_range(0, 3);
                nresp++;
            end
            grant_prev = grant;
            if ($urandom_range(0, 15) == 0) div_lat = $urandom_range(1, 5);
            for (int i = 0; i < N; i++) begin
                if (!req[i]) begin
                    if (gap[i] > 0) begin
                        gap[i]--;
                    end else if ($urandom_range(0, 2) == 0) begin
                        rn[i] = W'($urandom_range(0, 1023));
                        rd[i] = W'($urandom_range(1, 1023));
                        set_ops(i, rn[i], rd[i]);
                        req[i] = 1'b1;
                    end
                end else if (grant[i] == 1'b0 && $urandom_range(0, 31) == 0) begin
                    req[i] = 1'b0;
                end
            end
        end
        req = '0;
        for (int c = 0; c < 50 && busy; c++) begin
            @(posedge clk);
            #1;
        end
        chk("rand_resp_count", 32'(nresp >= 20), 1);
        chk("rand_drained", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
